// File: rtl/rtc_pkg.sv
// rtc_pkg: shared mode encoding, field limits, key indices and BCD helper for the HH:MM set-clock.
package rtc_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_t;
  localparam int HOURS_MAX = 23;
  localparam int MINUTES_MAX = 59;
  localparam int SECONDS_MAX = 59;
  localparam int KEY_MODE = 0;
  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 2;
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = (v >= 6'd60) ? 4'd6 : (v >= 6'd50) ? 4'd5 : (v >= 6'd40) ? 4'd4 :
        (v >= 6'd30) ? 4'd3 : (v >= 6'd20) ? 4'd2 : (v >= 6'd10) ? 4'd1 : 4'd0;
    return {t, 4'(v - {2'b00, t} * 6'd10)};
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-(MAX+1) up/down counter with clear/load and a wrap strobe on MAX->0 increments.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W = 6,
  parameter int RST = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);
  logic [W-1:0] r_count;
  logic         w_at_max;
  assign w_at_max = r_count == W'(MAX);
  assign o_wrap = i_inc && !i_dec && !i_clear && !i_load && w_at_max;
  assign o_count = r_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_count <= W'(RST);
    else if (i_clear) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_inc && !i_dec) r_count <= w_at_max ? '0 : r_count + 1'b1;
    else if (i_dec && !i_inc) r_count <= (r_count == '0) ? W'(MAX) : r_count - 1'b1;
  end
endmodule

// File: rtl/rtc_hhmm_setclock.sv
// rtc_hhmm_setclock: 24-hour HH:MM:SS clock with RUN/SET_HR/SET_MIN key FSM, blink mask and BCD output.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_hhmm_setclock
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BLINK_TICKS = 25_000_000,
  parameter int RESET_HOURS = 0,
  parameter int RESET_MINUTES = 0,
  parameter int H12 = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  key_n,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        pm,
`ifdef RTC_ALARM_EN
  input  logic [4:0]  alarm_hours,
  input  logic [5:0]  alarm_minutes,
  input  logic        alarm_en,
  output logic        alarm,
`endif
  output logic [1:0]  mode
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [2:0]    r_key, r_press;
  mode_t         r_mode;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink;
  logic          r_phase;
  logic          w_mode_ev, w_inc, w_dec, w_run, w_hold, w_tick, w_sec_wrap, w_min_wrap;
  logic [4:0]    w_hr12, w_disp_hr;
`ifdef RTC_ALARM_EN
  logic          w_hr_wrap;
`else
  logic          w_hr_wrap_unused;
`endif
  // A mode press swallows any inc/dec arriving in the same cycle
  assign w_mode_ev = r_press[KEY_MODE];
  assign w_inc = r_press[KEY_INC] && !r_press[KEY_DEC] && !w_mode_ev;
  assign w_dec = r_press[KEY_DEC] && !r_press[KEY_INC] && !w_mode_ev;
  assign w_run = r_mode == RUN;
  assign w_hold = !w_run || w_mode_ev;
  assign w_tick = !w_hold && r_presc == PW'(TICKS_PER_SEC - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key <= 3'b111;
      r_press <= 3'b000;
      r_mode <= RUN;
      r_presc <= '0;
    end else begin
      r_key <= key_n;
      r_press <= r_key & ~key_n;
      if (w_mode_ev) r_mode <= (r_mode == RUN) ? SET_HR : (r_mode == SET_HR) ? SET_MIN : RUN;
      r_presc <= (w_hold || r_presc == PW'(TICKS_PER_SEC - 1)) ? '0 : r_presc + 1'b1;
    end
  end
  mod_counter #(.MAX(SECONDS_MAX), .W(6), .RST(0)) u_sec (
    .clk(clk), .reset_n(reset_n), .i_inc(w_tick), .i_dec(1'b0), .i_clear(w_hold),
    .i_load(1'b0), .i_load_val(6'd0), .o_count(seconds), .o_wrap(w_sec_wrap)
  );
  mod_counter #(.MAX(MINUTES_MAX), .W(6), .RST(RESET_MINUTES)) u_min (
    .clk(clk), .reset_n(reset_n), .i_inc(w_sec_wrap || (r_mode == SET_MIN && w_inc)),
    .i_dec(r_mode == SET_MIN && w_dec), .i_clear(1'b0), .i_load(1'b0), .i_load_val(6'd0),
    .o_count(minutes), .o_wrap(w_min_wrap)
  );
  // Minute wraps only carry into hours while running; set-mode wraps stay local
  mod_counter #(.MAX(HOURS_MAX), .W(5), .RST(RESET_HOURS)) u_hr (
    .clk(clk), .reset_n(reset_n), .i_inc((w_run && w_min_wrap) || (r_mode == SET_HR && w_inc)),
    .i_dec(r_mode == SET_HR && w_dec), .i_clear(1'b0), .i_load(1'b0), .i_load_val(5'd0),
    .o_count(hours),
`ifdef RTC_ALARM_EN
    .o_wrap(w_hr_wrap)
`else
    .o_wrap(w_hr_wrap_unused)
`endif
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= '0;
      r_phase <= 1'b1;
    end else if (w_mode_ev || (!w_run && (r_press[KEY_INC] || r_press[KEY_DEC]))) begin
      r_blink <= '0;
      r_phase <= 1'b1;
    end else if (r_blink == BW'(BLINK_TICKS - 1)) begin
      r_blink <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end
  assign blank = r_phase ? 4'b0000 : (r_mode == SET_HR) ? 4'b1100 :
                 (r_mode == SET_MIN) ? 4'b0011 : 4'b0000;
  assign mode = r_mode;
  assign w_hr12 = (hours >= 5'd12) ? hours - 5'd12 : hours;
  assign w_disp_hr = (H12 == 0) ? hours : (w_hr12 == 5'd0) ? 5'd12 : w_hr12;
  assign digits = {to_bcd({1'b0, w_disp_hr}), to_bcd(minutes)};
  assign pm = (H12 != 0) && (hours >= 5'd12);
`ifdef RTC_ALARM_EN
  logic       r_alarm;
  logic [5:0] w_nxt_min;
  logic [4:0] w_nxt_hr;
  // Compare against the time the current tick is about to produce
  assign w_nxt_min = w_min_wrap ? 6'd0 : minutes + 1'b1;
  assign w_nxt_hr = w_hr_wrap ? 5'd0 : w_min_wrap ? hours + 1'b1 : hours;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_alarm <= 1'b0;
    else if (!alarm_en || |r_press) r_alarm <= 1'b0;
    else if (w_sec_wrap && w_nxt_hr == alarm_hours && w_nxt_min == alarm_minutes) r_alarm <= 1'b1;
  end
  assign alarm = r_alarm;
`endif
endmodule

// File: tb/tb_rtc_hhmm_setclock.sv
// tb_rtc_hhmm_setclock: directed plus random key stimulus against a seconds-of-day reference model.
module tb_rtc_hhmm_setclock;
  localparam int TPS = 4;
  localparam int BT = 3;
  localparam int RH = 23;
  localparam int RM = 59;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  key_n = 3'b111;
  logic [2:0]  key12_n = 3'b111;
  logic [4:0]  hours, hours12;
  logic [5:0]  minutes, seconds, minutes12, seconds12;
  logic [15:0] digits, digits12;
  logic [3:0]  blank, blank12;
  logic        pm, pm12;
  logic [1:0]  mode, mode12;
  int checks = 0;
  int failures = 0;
  int tod, md, run_age, bage;
  logic [2:0] pend, prev;

  always #5 clk = ~clk;

  rtc_hhmm_setclock #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BT), .RESET_HOURS(RH),
                      .RESET_MINUTES(RM), .H12(0)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .hours(hours), .minutes(minutes),
    .seconds(seconds), .digits(digits), .blank(blank), .pm(pm), .mode(mode)
  );
  rtc_hhmm_setclock #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BT), .RESET_HOURS(0),
                      .RESET_MINUTES(0), .H12(1)) dut12 (
    .clk(clk), .reset_n(reset_n), .key_n(key12_n), .hours(hours12), .minutes(minutes12),
    .seconds(seconds12), .digits(digits12), .blank(blank12), .pm(pm12), .mode(mode12)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    tod = RH * 3600 + RM * 60;
    md = 0;
    run_age = 0;
    bage = 0;
    pend = 3'b000;
    prev = 3'b111;
  endtask

  // One clock of the reference: key edges become events one clock later
  task automatic m_step(input logic [2:0] k);
    logic [2:0] ev;
    int h, m;
    ev = pend;
    pend = prev & ~k;
    prev = k;
    h = tod / 3600;
    m = (tod / 60) % 60;
    if (md == 0 && !ev[0]) begin
      if (run_age % TPS == TPS - 1) tod = (tod + 1) % 86400;
      run_age++;
    end else begin
      run_age = 0;
      tod = tod - tod % 60;
    end
    if (!ev[0] && ev[1] != ev[2] && md != 0) begin
      if (md == 1) h = (h + (ev[1] ? 1 : 23)) % 24;
      else m = (m + (ev[1] ? 1 : 59)) % 60;
      tod = h * 3600 + m * 60;
    end
    bage = (ev[0] || (md != 0 && (ev[1] || ev[2]))) ? 0 : bage + 1;
    if (ev[0]) md = (md + 1) % 3;
  endtask

  function automatic logic [15:0] m_digits();
    int h, m;
    h = tod / 3600;
    m = (tod / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [3:0] m_blank();
    if ((bage / BT) % 2 == 0) return 4'b0000;
    return (md == 1) ? 4'b1100 : (md == 2) ? 4'b0011 : 4'b0000;
  endfunction

  task automatic check_dut();
    chk("hours", 16'(hours), 16'(tod / 3600));
    chk("minutes", 16'(minutes), 16'((tod / 60) % 60));
    chk("seconds", 16'(seconds), 16'(tod % 60));
    chk("digits", digits, m_digits());
    chk("blank", 16'(blank), 16'(m_blank()));
    chk("mode", 16'(mode), 16'(md));
    chk("pm", 16'(pm), 16'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      m_step(key_n);
      @(negedge clk);
      check_dut();
    end
  endtask

  task automatic press(input logic [2:0] mask);
    key_n = ~mask;
    cyc(2);
    key_n = 3'b111;
    cyc(2);
  endtask

  task automatic press12(input logic [2:0] mask);
    key12_n = ~mask;
    cyc(2);
    key12_n = 3'b111;
    cyc(2);
  endtask

  // Asserts reset between clock edges so the async path is observed before any edge
  task automatic do_reset();
    key_n = 3'b111;
    key12_n = 3'b111;
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check_dut();
    repeat (2) @(negedge clk);
    check_dut();
    reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();
    cyc(239);
    chk("pre_roll_digits", digits, 16'h2359);
    chk("pre_roll_sec", 16'(seconds), 16'd59);
    cyc(1);
    chk("roll_digits", digits, 16'h0000);
    chk("roll_sec", 16'(seconds), 16'd0);
    cyc(10);
    do_reset();
    press(3'b001);
    chk("enter_set_hr", 16'(mode), 16'd1);
    for (int i = 0; i < 8 && m_blank() == 4'b0000; i++) cyc(1);
    key_n = 3'b011;
    cyc(1);
    chk("blank_before_press", 16'(blank), 16'h000c);
    cyc(1);
    chk("blank_after_press", 16'(blank), 16'd0);
    key_n = 3'b111;
    cyc(2);
    press(3'b100);
    chk("set_hr_21", 16'(hours), 16'd21);
    chk("set_hr_sec0", 16'(seconds), 16'd0);
    cyc(7);
    press(3'b001);
    chk("enter_set_min", 16'(mode), 16'd2);
    chk("set_min_blank0", 16'(blank), 16'd0);
    cyc(8);
    press(3'b010);
    chk("min_wrap", 16'(minutes), 16'd0);
    chk("min_wrap_hours", 16'(hours), 16'd21);
    press(3'b110);
    chk("incdec_min", 16'(minutes), 16'd0);
    press(3'b001);
    cyc(20);
    for (int i = 0; i < 400; i++) begin
      key_n = {3{1'b1}};
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) key_n[b] = 1'b0;
      cyc(1);
    end
    key_n = 3'b111;
    cyc(3);
    for (int i = 0; i < 3 && md != 2; i++) press(3'b001);
    chk("pre_reset_mode", 16'(mode), 16'd2);
    press(3'b010);
    press(3'b010);
    do_reset();
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_digits", digits, 16'h2359);
    chk("rst_sec", 16'(seconds), 16'd0);
    chk("rst_blank", 16'(blank), 16'd0);
    chk("h12_midnight", 16'(digits12[15:8]), 16'h0012);
    chk("h12_midnight_pm", 16'(pm12), 16'd0);
    press12(3'b001);
    repeat (13) press12(3'b010);
    chk("h12_hours", 16'(hours12), 16'd13);
    chk("h12_1pm", 16'(digits12[15:8]), 16'h0001);
    chk("h12_min", 16'(digits12[7:0]), 16'h0000);
    chk("h12_pm", 16'(pm12), 16'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
